// File: rtl/enc_ctrl_fsm_p.sv
// Turbo-encoder control FSM: record, interleaver wait, data encode, tail.
// Owns bit/tail/timeout counters, block length latch and block counter.
module enc_ctrl_fsm_p #(
    parameter int CNT_W       = 13,
    parameter int BLK_SMALL   = 1056,
    parameter int BLK_LARGE   = 6144,
    parameter int TAIL_LEN    = 4,
    parameter int TMO_W       = 16,
    parameter int INT_TIMEOUT = 4096,
    parameter int BLKCNT_W    = 16
) (
    input  logic                clock,
    input  logic                aclr,
    input  logic                cbs_ready,
    input  logic                blk_sel,
    input  logic                int_ready,
    input  logic                out_ready,
    output logic                ready,
    output logic                record_en,
    output logic                delay_wen,
    output logic                delay_ren,
    output logic                enc_en,
    output logic                counter_en,
    output logic                close_switch,
    output logic                tail_mode,
    output logic                out_valid,
    output logic                done,
    output logic                err_timeout,
    output logic [BLKCNT_W-1:0] blk_count,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_INIT         = 3'd0,
        S_RECORD       = 3'd1,
        S_WAIT_INT     = 3'd2,
        S_OPERATE      = 3'd3,
        S_LAST_OPERATE = 3'd4,
        S_TAIL         = 3'd5,
        S_WAIT_TAIL    = 3'd6,
        S_LAST_TAIL    = 3'd7
    } state_t;

    localparam int TL_W = $clog2(TAIL_LEN);

    localparam logic [CNT_W-1:0] LEN_SMALL = CNT_W'(BLK_SMALL);
    localparam logic [CNT_W-1:0] LEN_LARGE = CNT_W'(BLK_LARGE);
    localparam logic [TL_W-1:0]  TAIL_LAST = TL_W'(TAIL_LEN - 3);
    localparam logic [TMO_W-1:0] TMO_LAST  =
        TMO_W'((INT_TIMEOUT > 0) ? INT_TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};
    localparam bit               TMO_ON    = (INT_TIMEOUT != 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [CNT_W-1:0]    blk_len, blk_len_d;
    logic [TL_W-1:0]     tail_cnt, tail_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
    logic [BLKCNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                valid_raw;
    logic                adv;

    // Output words are offered in every state from OPERATE to LAST_TAIL;
    // the handshake decides whether the pipeline moves this cycle.
    assign valid_raw = (state_q == S_OPERATE)      ||
                       (state_q == S_LAST_OPERATE) ||
                       (state_q == S_TAIL)         ||
                       (state_q == S_WAIT_TAIL)    ||
                       (state_q == S_LAST_TAIL);
    assign adv = valid_raw & out_ready;

    // State, counters and the registered pulses.
    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q   <= S_INIT;
            bit_cnt   <= '0;
            blk_len   <= LEN_SMALL;
            tail_cnt  <= '0;
            tmo_cnt   <= '0;
            blk_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt   <= bit_cnt_d;
            blk_len   <= blk_len_d;
            tail_cnt  <= tail_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and counter updates; stalled states simply hold.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt;
        blk_len_d  = blk_len;
        tail_cnt_d = tail_cnt;
        tmo_cnt_d  = tmo_cnt;
        blk_cnt_d  = blk_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (cbs_ready) begin
                    state_d   = S_RECORD;
                    blk_len_d = blk_sel ? LEN_LARGE : LEN_SMALL;
                    bit_cnt_d = '0;
                end
            end
            S_RECORD: begin
                state_d   = S_WAIT_INT;
                tmo_cnt_d = '0;
            end
            S_WAIT_INT: begin
                // A late int_ready still wins over an expiring timeout.
                if (int_ready) begin
                    state_d = S_OPERATE;
                end else if (TMO_ON && tmo_cnt == TMO_LAST) begin
                    state_d = S_INIT;
                    err_d   = 1'b1;
                end else if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            S_OPERATE: begin
                if (adv) begin
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == blk_len - CNT_W'(2)) begin
                        state_d = S_LAST_OPERATE;
                    end
                end
            end
            S_LAST_OPERATE: begin
                if (adv) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (adv) begin
                    state_d    = S_WAIT_TAIL;
                    tail_cnt_d = '0;
                end
            end
            S_WAIT_TAIL: begin
                if (adv) begin
                    tail_cnt_d = tail_cnt + 1'b1;
                    if (tail_cnt == TAIL_LAST) begin
                        state_d = S_LAST_TAIL;
                    end
                end
            end
            S_LAST_TAIL: begin
                if (adv) begin
                    state_d   = S_INIT;
                    done_d    = 1'b1;
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Datapath strobes decoded from state; stalls freeze the datapath.
    always_comb begin
        ready        = (state_q == S_INIT);
        record_en    = (state_q == S_RECORD);
        delay_wen    = (state_q == S_RECORD)  ||
                       (state_q == S_WAIT_INT) ||
                       (state_q == S_OPERATE)  ||
                       (state_q == S_LAST_OPERATE);
        delay_ren    = (state_q == S_OPERATE);
        counter_en   = (state_q == S_OPERATE) ||
                       (state_q == S_LAST_OPERATE);
        enc_en       = (state_q == S_OPERATE)      ||
                       (state_q == S_LAST_OPERATE) ||
                       (state_q == S_TAIL)         ||
                       (state_q == S_WAIT_TAIL);
        close_switch = (state_q == S_LAST_OPERATE) ||
                       (state_q == S_TAIL)         ||
                       (state_q == S_WAIT_TAIL);
        tail_mode    = (state_q == S_TAIL)      ||
                       (state_q == S_WAIT_TAIL) ||
                       (state_q == S_LAST_TAIL);
        out_valid    = valid_raw;
        if (valid_raw && !out_ready) begin
            enc_en     = 1'b0;
            counter_en = 1'b0;
            delay_ren  = 1'b0;
            delay_wen  = 1'b0;
        end
    end

    assign done        = done_q;
    assign err_timeout = err_q;
    assign blk_count   = blk_cnt_q;
    assign state       = state_q;

endmodule
